// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// State encoding and port indices used by the arbiter and its picker.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the last-grant flag lives in the parent.
// On a tie the port that did not win last time is chosen.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   output logic       winner_o,
   output logic       any_o
);
   import dmem_arbiter_pkg::*;

   always_comb begin
      winner_o = PORT_CPU;
      any_o    = |req_i;
      if (req_i == 2'b11) begin
         winner_o = ~last_gnt_i;
      end else if (req_i[1]) begin
         winner_o = PORT_AUX;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory BRAM between the CPU port and an auxiliary
// master, running each grant through an issue/wait/respond sequence.
module dmem_arbiter #(
   parameter int XLEN         = 32,
   parameter int ADDR_WIDTH   = 11,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_we0,
   input  logic                  i_we1,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [XLEN-1:0]       i_wdata0,
   input  logic [XLEN-1:0]       i_wdata1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_valid0,
   output logic                  o_valid1,
   output logic [XLEN-1:0]       o_rdata,
   output logic                  o_busy,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [XLEN-1:0]       o_mem_wdata,
   input  logic [XLEN-1:0]       i_mem_q
);
   import dmem_arbiter_pkg::*;

   localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic                  win_q, win_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic winner;
   logic any_req;
   logic gnt0, gnt1;

   rr_arbiter2 u_pick (
      .req_i      ({i_req1, i_req0}),
      .last_gnt_i (last_q),
      .winner_o   (winner),
      .any_o      (any_req)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         last_q  <= PORT_AUX;
         win_q   <= PORT_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      o_mem_en = 1'b0;
      o_mem_we = 1'b0;
      o_valid0 = 1'b0;
      o_valid1 = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_ISSUE;
               last_d  = winner;
               win_d   = winner;
               we_d    = winner ? i_we1 : i_we0;
               addr_d  = winner ? i_addr1 : i_addr0;
               wdata_d = winner ? i_wdata1 : i_wdata0;
               gnt0    = (winner == PORT_CPU);
               gnt1    = (winner == PORT_AUX);
            end
         end
         S_ISSUE: begin
            o_mem_en = 1'b1;
            o_mem_we = we_q;
            cnt_d    = LAT;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 3'd1) begin
               rdata_d = i_mem_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_valid0 = (win_q == PORT_CPU);
            o_valid1 = (win_q == PORT_AUX);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A grant during reset would announce a transaction that is never latched
   assign o_gnt0      = gnt0 & ~i_rst;
   assign o_gnt1      = gnt1 & ~i_rst;
   assign o_busy      = (state_q != S_IDLE);
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, corner sequences and a random
// run against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int RL_A = 1;
   localparam int TXN  = 3 + RL_A;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reqA0 = 0, reqA1 = 0, weA0 = 0, weA1 = 0;
   logic [10:0] addrA0 = 0, addrA1 = 0;
   logic [31:0] wdA0 = 0, wdA1 = 0;
   logic        gA0, gA1, vA0, vA1, busyA, enA, mweA;
   logic [31:0] rdA, mwdA, qA;
   logic [10:0] maddrA;

   logic        reqB = 0;
   logic [10:0] addrB = 0;
   logic        gB0, gB1, vB0, vB1, busyB, enB, mweB;
   logic [31:0] rdB, mwdB, qB;
   logic [10:0] maddrB;

   dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(11), .READ_LATENCY(RL_A)) dutA (
      .i_clk(clk), .i_rst(rst),
      .i_req0(reqA0), .i_req1(reqA1), .i_we0(weA0), .i_we1(weA1),
      .i_addr0(addrA0), .i_addr1(addrA1),
      .i_wdata0(wdA0), .i_wdata1(wdA1),
      .o_gnt0(gA0), .o_gnt1(gA1), .o_valid0(vA0), .o_valid1(vA1),
      .o_rdata(rdA), .o_busy(busyA), .o_mem_en(enA), .o_mem_we(mweA),
      .o_mem_addr(maddrA), .o_mem_wdata(mwdA), .i_mem_q(qA)
   );

   dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(11), .READ_LATENCY(3)) dutB (
      .i_clk(clk), .i_rst(rst),
      .i_req0(reqB), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
      .i_addr0(addrB), .i_addr1(11'd0),
      .i_wdata0(32'd0), .i_wdata1(32'd0),
      .o_gnt0(gB0), .o_gnt1(gB1), .o_valid0(vB0), .o_valid1(vB1),
      .o_rdata(rdB), .o_busy(busyB), .o_mem_en(enB), .o_mem_we(mweB),
      .o_mem_addr(maddrB), .o_mem_wdata(mwdB), .i_mem_q(qB)
   );

   // BRAM models: latency 1 for A, 3-stage pipeline for B
   logic [31:0] memA [0:2047];
   logic [31:0] memB [0:2047];
   logic [31:0] pipeB [0:2];
   logic        clr = 0, pre = 0;
   logic [10:0] pre_addr = 0;
   logic [31:0] pre_data = 0;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 2048; i++) begin
            memA[i] <= '0;
            memB[i] <= '0;
         end
      end else if (pre) begin
         memA[pre_addr] <= pre_data;
         memB[pre_addr] <= pre_data;
      end
      if (enA) begin
         if (mweA) memA[maddrA] <= mwdA;
         qA <= memA[maddrA];
      end
      if (enB) begin
         if (mweB) memB[maddrB] <= mwdB;
         pipeB[0] <= memB[maddrB];
      end
      pipeB[1] <= pipeB[0];
      pipeB[2] <= pipeB[1];
   end
   assign qB = pipeB[2];

   // Event log for DUT A
   logic        mon = 0;
   int          gcyc[$];
   logic        gport[$];
   logic        vport[$];
   logic [31:0] vdata[$];

   always @(negedge clk) begin
      if (mon) begin
         if (gA0 | gA1) begin
            gcyc.push_back(cyc);
            gport.push_back(gA1);
         end
         if (vA0 | vA1) begin
            vport.push_back(vA1);
            vdata.push_back(rdA);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; reqA0 = 0; reqA1 = 0; reqB = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic mem_clear();
      @(posedge clk); #1 clr = 1;
      @(posedge clk); #1 clr = 0;
   endtask

   task automatic preload(input logic [10:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pre = 1; pre_addr = a; pre_data = d;
      @(posedge clk); #1 pre = 0;
   endtask

   task automatic clear_log();
      gcyc.delete(); gport.delete(); vport.delete(); vdata.delete();
   endtask

   task automatic wait_gnts(input int n, input string nm);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk); #1;
         if (gcyc.size() >= n) break;
      end
      chk({nm, "_bound"}, 32'(k < 60), 32'd1);
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic txnA(input vec_t v, input int idx);
      int vk = 0, nen = 0, nwe = 0, nval = 0, noth = 0;
      logic [10:0] ea = 0;
      logic [31:0] ew = 0, rd = 0;
      string nm;
      nm = $sformatf("vec%0d", idx);
      @(posedge clk); #1;
      if (v.port) begin
         reqA1 = 1; weA1 = v.we; addrA1 = v.addr; wdA1 = v.wdata;
      end else begin
         reqA0 = 1; weA0 = v.we; addrA0 = v.addr; wdA0 = v.wdata;
      end
      @(negedge clk);
      chk({nm, "_gnt"}, {gA1, gA0}, v.port ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      reqA0 = 0; reqA1 = 0;
      addrA0 = 11'($urandom); addrA1 = 11'($urandom);
      wdA0 = $urandom; wdA1 = $urandom;
      weA0 = 1'($urandom); weA1 = 1'($urandom);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (enA) begin
            nen++; ea = maddrA; ew = mwdA;
            if (mweA) nwe++;
         end
         if (v.port ? vA1 : vA0) begin
            nval++;
            if (vk == 0) begin vk = k; rd = rdA; end
         end
         if (v.port ? vA0 : vA1) noth++;
      end
      chk({nm, "_en_cnt"}, nen, 1);
      chk({nm, "_we_cnt"}, nwe, 32'(v.we));
      chk({nm, "_maddr"}, 32'(ea), 32'(v.addr));
      chk({nm, "_lat"}, vk, 3);
      chk({nm, "_vcnt"}, nval, 1);
      chk({nm, "_vother"}, noth, 0);
      if (v.we) chk({nm, "_mwdata"}, ew, v.wdata);
      else      chk({nm, "_rdata"}, rd, v.exp);
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 11'h010, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 11'h020, 32'h12345678, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 11'h020, 32'h0,        32'h12345678};
      vecs[3] = '{1'b0, 1'b1, 11'h7FC, 32'hA5A5A5A5, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 11'h7FC, 32'h0,        32'hA5A5A5A5};
      vecs[5] = '{1'b0, 1'b0, 11'h000, 32'h0,        32'h0};
      vecs[6] = '{1'b1, 1'b1, 11'h010, 32'h0,        32'h0};
      vecs[7] = '{1'b0, 1'b0, 11'h010, 32'h0,        32'h0};

      do_reset();
      @(negedge clk);
      chk("rst_outs", {gA0, gA1, vA0, vA1, busyA, enA, mweA}, 7'd0);
      chk("rst_maddr", 32'(maddrA), 0);
      chk("rst_mwdata", mwdA, 0);
      chk("rst_rdata", rdA, 0);

      mem_clear();
      preload(11'h010, 32'hDEADBEEF);
      for (int i = 0; i < 8; i++) txnA(vecs[i], i);

      // Contention from reset: strict alternation starting with port 0
      do_reset();
      preload(11'h100, 32'h11110000);
      preload(11'h104, 32'h22220001);
      clear_log(); mon = 1;
      @(posedge clk); #1;
      reqA0 = 1; reqA1 = 1; weA0 = 0; weA1 = 0;
      addrA0 = 11'h100; addrA1 = 11'h104;
      wait_gnts(4, "cont");
      @(posedge clk); #1 reqA0 = 0; reqA1 = 0;
      repeat (8) @(negedge clk);
      mon = 0;
      chk("cont_ngnt", gcyc.size(), 4);
      chk("cont_nval", vdata.size(), 4);
      if (gcyc.size() == 4 && vdata.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_port%0d", i), 32'(gport[i]), i % 2);
            chk($sformatf("cont_gap%0d", i), gcyc[i] - gcyc[0], 4 * i);
            chk($sformatf("cont_vport%0d", i), 32'(vport[i]), i % 2);
            chk($sformatf("cont_data%0d", i), vdata[i],
                (i % 2) ? 32'h22220001 : 32'h11110000);
         end
      end

      // Held request: address change lands on the following transaction
      do_reset();
      clear_log(); mon = 1;
      @(posedge clk); #1;
      reqA0 = 1; weA0 = 0; addrA0 = 11'h100;
      wait_gnts(1, "hold1");
      @(posedge clk); #1 addrA0 = 11'h104;
      wait_gnts(3, "hold3");
      @(posedge clk); #1 reqA0 = 0;
      repeat (8) @(negedge clk);
      mon = 0;
      chk("hold_ngnt", gcyc.size(), 3);
      chk("hold_nval", vdata.size(), 3);
      if (gcyc.size() == 3 && vdata.size() == 3) begin
         chk("hold_gap1", gcyc[1] - gcyc[0], 4);
         chk("hold_gap2", gcyc[2] - gcyc[1], 4);
         chk("hold_ports", {31'd0, gport[0] | gport[1] | gport[2]}, 0);
         chk("hold_d0", vdata[0], 32'h11110000);
         chk("hold_d1", vdata[1], 32'h22220001);
         chk("hold_d2", vdata[2], 32'h22220001);
      end

      // Reset during WAIT after a port-0 win
      do_reset();
      @(posedge clk); #1;
      reqA0 = 1; weA0 = 0; addrA0 = 11'h104; wdA0 = 32'hFFFF0000;
      @(negedge clk);
      chk("rstw_gnt", {gA1, gA0}, 2'b01);
      @(posedge clk); #1 reqA0 = 0;
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("rstw_inwait", {busyA, enA}, 2'b10);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("rstw_outs", {gA0, gA1, vA0, vA1, busyA, enA, mweA}, 7'd0);
      chk("rstw_maddr", 32'(maddrA), 0);
      chk("rstw_mwdata", mwdA, 0);
      chk("rstw_rdata", rdA, 0);
      begin
         int nv = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (vA0 | vA1 | busyA) nv++;
         end
         chk("rstw_novalid", nv, 0);
      end
      @(posedge clk); #1 reqA0 = 1; reqA1 = 1;
      @(negedge clk);
      chk("rstw_tie", {gA1, gA0}, 2'b01);
      @(posedge clk); #1 reqA0 = 0; reqA1 = 0;
      repeat (6) @(negedge clk);

      // Three-cycle BRAM on the second instance
      do_reset();
      preload(11'h030, 32'hCAFEF00D);
      @(posedge clk); #1 reqB = 1; addrB = 11'h030;
      @(negedge clk);
      chk("lat3_gnt", {gB1, gB0}, 2'b01);
      @(posedge clk); #1 reqB = 0; addrB = 11'h7FF;
      begin
         int vk = 0, nen = 0, nwe = 0, n1 = 0;
         logic bz = 0;
         logic [31:0] rd = 0;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (enB) begin nen++; if (mweB) nwe++; end
            if (vB0 && vk == 0) begin vk = k; rd = rdB; end
            if (vB1) n1++;
            if (k == 1) bz = busyB;
         end
         chk("lat3_lat", vk, 5);
         chk("lat3_rdata", rd, 32'hCAFEF00D);
         chk("lat3_en", nen, 1);
         chk("lat3_we", nwe, 0);
         chk("lat3_v1", n1, 0);
         chk("lat3_busy", 32'(bz), 1);
         chk("lat3_mwdata", mwdB, 0);
      end

      // Random traffic against a transaction-level model
      do_reset();
      mem_clear();
      begin
         logic [31:0] ref_mem [0:7];
         int   mg = -100;
         logic mlast = 1, mport = 0, mwe = 0;
         logic [31:0] mexp = 0;
         for (int i = 0; i < 8; i++) ref_mem[i] = 0;
         for (int i = 0; i < 520; i++) begin
            int t;
            logic free, w, ev;
            @(posedge clk); #1;
            if (i < 500) begin
               reqA0 = ($urandom % 3) != 0;
               reqA1 = ($urandom % 2) != 0;
            end else begin
               reqA0 = 0; reqA1 = 0;
            end
            weA0 = 1'($urandom); weA1 = 1'($urandom);
            addrA0 = 11'(($urandom % 8) * 4);
            addrA1 = 11'(($urandom % 8) * 4);
            wdA0 = $urandom; wdA1 = $urandom;
            @(negedge clk);
            t = cyc;
            free = (t >= mg + TXN);
            w = (reqA0 && reqA1) ? ~mlast : reqA1;
            ev = (t == mg + 2 + RL_A);
            chk("rnd_gnt", {gA1, gA0},
                (free && (reqA0 || reqA1)) ? (w ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd_busy", 32'(busyA), 32'(!free));
            chk("rnd_en", 32'(enA), 32'(t == mg + 1));
            chk("rnd_we", 32'(mweA), 32'(t == mg + 1 && mwe));
            chk("rnd_valid", {vA1, vA0},
                ev ? (mport ? 2'b10 : 2'b01) : 2'b00);
            if (ev && !mwe) chk("rnd_rdata", rdA, mexp);
            if (free && (reqA0 || reqA1)) begin
               logic [10:0] a;
               mg = t; mport = w; mlast = w;
               mwe = w ? weA1 : weA0;
               a = w ? addrA1 : addrA0;
               if (mwe) ref_mem[a[4:2]] = w ? wdA1 : wdA0;
               else     mexp = ref_mem[a[4:2]];
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
